// File: rtl/line_mem_responder_if.sv
// ----------------------------------------------------------------------------
// line_mem_responder_if
//   Cache-line memory bus between the instruction/data caches and the
//   line memory responder. Each cache issues a one-cycle strobe with an
//   address (and, for the data cache, a direction and write line) and gets
//   back a one-cycle done pulse with the read line on its datain bus.
//
// Signals
//   ICACHE_strobe   cache -> responder  one-cycle I-line read request
//   ICACHE_addr     cache -> responder  I-line byte address
//   ICACHE_done     responder -> cache  one-cycle completion, datain valid
//   ICACHE_datain   responder -> cache  line returned to the I-cache
//   DCACHE_strobe   cache -> responder  one-cycle D-line request
//   DCACHE_addr     cache -> responder  D-line byte address
//   DCACHE_rw       cache -> responder  1 = write line, 0 = read line
//   DCACHE_dataout  cache -> responder  line to be written
//   DCACHE_done     responder -> cache  one-cycle completion
//   DCACHE_datain   responder -> cache  line returned to the D-cache
//
// Modports
//   master : cache side (drives strobes/addresses)
//   slave  : responder side (drives done/datain)
// ----------------------------------------------------------------------------
interface line_mem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
);
    logic                  ICACHE_strobe;
    logic [ADDR_WIDTH-1:0] ICACHE_addr;
    logic                  ICACHE_done;
    logic [LINE_WIDTH-1:0] ICACHE_datain;

    logic                  DCACHE_strobe;
    logic [ADDR_WIDTH-1:0] DCACHE_addr;
    logic                  DCACHE_rw;
    logic [LINE_WIDTH-1:0] DCACHE_dataout;
    logic                  DCACHE_done;
    logic [LINE_WIDTH-1:0] DCACHE_datain;

    modport master (
        output ICACHE_strobe, ICACHE_addr,
        input  ICACHE_done, ICACHE_datain,
        output DCACHE_strobe, DCACHE_addr, DCACHE_rw, DCACHE_dataout,
        input  DCACHE_done, DCACHE_datain
    );

    modport slave (
        input  ICACHE_strobe, ICACHE_addr,
        output ICACHE_done, ICACHE_datain,
        input  DCACHE_strobe, DCACHE_addr, DCACHE_rw, DCACHE_dataout,
        output DCACHE_done, DCACHE_datain
    );
endinterface

// File: rtl/line_mem_responder.sv
// ----------------------------------------------------------------------------
// line_mem_responder
//   Responder end of the cache-line memory bus. Serves whole-line reads for
//   the I-cache and reads/writes for the D-cache out of an on-chip word-wide
//   synchronous RAM, one beat (RAM word) per cycle. The two ports are
//   arbitrated round-robin and only one line transfer is in flight at a time.
//
// Ports
//   clk  : clock
//   rst  : asynchronous reset, active high (RAM contents are not reset)
//   bus  : line_mem_responder_if.slave (strobe/addr/rw/dataout in,
//          done/datain out, for both the I and D ports)
//
// Timing (idle responder, strobe in cycle N)
//   read  done in cycle N + BEATS + 3
//   write done in cycle N + BEATS + 2
// ----------------------------------------------------------------------------
module line_mem_responder #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    CACHE_LINE_SIZE = 256,
    parameter int                    MEM_WORDS       = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    line_mem_responder_if.slave   bus
);

    localparam int BEATS      = CACHE_LINE_SIZE / DATA_WIDTH;
    localparam int BEAT_W     = $clog2(BEATS);
    localparam int IDX_W      = $clog2(MEM_WORDS);
    localparam int WORD_SHIFT = $clog2(DATA_WIDTH / 8);

    // The beat counter needs one extra bit: a read runs one count past the
    // last issued beat to collect the final word out of the RAM.
    localparam logic [BEAT_W:0] LAST_RD = (BEAT_W + 1)'(BEATS);
    localparam logic [BEAT_W:0] LAST_WR = (BEAT_W + 1)'(BEATS - 1);
    localparam logic [BEAT_W:0] BEAT_ONE = (BEAT_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RESP
    } state_t;

    // Byte address -> first RAM word of the line. Line offset bits are
    // masked off and anything above the RAM depth simply wraps.
    function automatic logic [IDX_W-1:0] lineIndex(input logic [ADDR_WIDTH-1:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> WORD_SHIFT) & ~IDX_W'(BEATS - 1);
    endfunction

    state_t                     r_state;
    state_t                     w_next_state;

    logic                       r_i_pend;
    logic [ADDR_WIDTH-1:0]      r_i_addr;
    logic                       r_d_pend;
    logic [ADDR_WIDTH-1:0]      r_d_addr;
    logic                       r_d_rw;
    logic [CACHE_LINE_SIZE-1:0] r_d_wline;

    logic                       r_grant_d;
    logic                       r_last_d;
    logic                       w_grant_i;
    logic                       w_grant_d;
    logic                       w_i_busy;
    logic                       w_d_busy;

    logic [BEAT_W:0]            r_beat;
    logic [BEAT_W-1:0]          w_beat_lo;
    logic [BEAT_W-1:0]          w_cap_lo;

    logic [DATA_WIDTH-1:0]      r_mem [MEM_WORDS];
    logic [DATA_WIDTH-1:0]      r_ram_q;
    logic [IDX_W-1:0]           w_base_idx;
    logic [IDX_W-1:0]           w_ram_addr;
    logic                       w_ram_we;
    logic [DATA_WIDTH-1:0]      w_ram_wdata;

    logic [CACHE_LINE_SIZE-1:0] r_line;
    logic [CACHE_LINE_SIZE-1:0] w_line_done;
    logic [CACHE_LINE_SIZE-1:0] r_i_datain;
    logic [CACHE_LINE_SIZE-1:0] r_d_datain;

    // A port is busy while it is waiting or while its own transfer is being
    // served; strobes on a busy port are dropped.
    assign w_i_busy = r_i_pend || ((r_state != S_IDLE) && !r_grant_d);
    assign w_d_busy = r_d_pend || ((r_state != S_IDLE) && r_grant_d);

    assign w_beat_lo = r_beat[BEAT_W-1:0];
    // Word returned by the RAM this cycle belongs to the previous beat; at
    // the end of a read (count == BEATS) this wraps to the top slot.
    assign w_cap_lo  = w_beat_lo - BEAT_W'(1);

    assign w_base_idx  = lineIndex(r_grant_d ? r_d_addr : r_i_addr);
    assign w_ram_addr  = w_base_idx + IDX_W'(w_beat_lo);
    assign w_ram_we    = (r_state == S_WR);
    assign w_ram_wdata = r_d_wline[w_beat_lo * DATA_WIDTH +: DATA_WIDTH];

    // The last word lands in the top slot straight from the RAM output, so
    // the completed line is available in the same cycle it is captured.
    assign w_line_done = {r_ram_q, r_line[CACHE_LINE_SIZE-DATA_WIDTH-1:0]};

    assign bus.ICACHE_done   = (r_state == S_RESP) && !r_grant_d;
    assign bus.DCACHE_done   = (r_state == S_RESP) && r_grant_d;
    assign bus.ICACHE_datain = r_i_datain;
    assign bus.DCACHE_datain = r_d_datain;

    // Word-wide synchronous RAM with one cycle of read latency.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_mem[w_ram_addr] <= w_ram_wdata;
        end
        r_ram_q <= r_mem[w_ram_addr];
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Arbitration and next state. Grants happen only in IDLE; with both
    // ports waiting the one not granted last time wins.
    always_comb begin
        w_next_state = r_state;
        w_grant_d    = 1'b0;
        w_grant_i    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_grant_d = r_d_pend && (!r_i_pend || !r_last_d);
                w_grant_i = r_i_pend && !w_grant_d;
                if (w_grant_d) begin
                    w_next_state = r_d_rw ? S_WR : S_RD;
                end else if (w_grant_i) begin
                    w_next_state = S_RD;
                end
            end
            S_RD: begin
                if (r_beat == LAST_RD) begin
                    w_next_state = S_RESP;
                end
            end
            S_WR: begin
                if (r_beat == LAST_WR) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Request capture, grant bookkeeping, beat counting and line assembly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i_pend   <= 1'b0;
            r_i_addr   <= '0;
            r_d_pend   <= 1'b0;
            r_d_addr   <= '0;
            r_d_rw     <= 1'b0;
            r_d_wline  <= '0;
            r_grant_d  <= 1'b0;
            r_last_d   <= 1'b0;
            r_beat     <= '0;
            r_line     <= '0;
            r_i_datain <= '0;
            r_d_datain <= '0;
        end else begin
            if (w_grant_i) begin
                r_i_pend <= 1'b0;
            end else if (bus.ICACHE_strobe && !w_i_busy) begin
                r_i_pend <= 1'b1;
                r_i_addr <= bus.ICACHE_addr;
            end

            if (w_grant_d) begin
                r_d_pend <= 1'b0;
            end else if (bus.DCACHE_strobe && !w_d_busy) begin
                r_d_pend  <= 1'b1;
                r_d_addr  <= bus.DCACHE_addr;
                r_d_rw    <= bus.DCACHE_rw;
                r_d_wline <= bus.DCACHE_dataout;
            end

            if (w_grant_i || w_grant_d) begin
                r_grant_d <= w_grant_d;
                r_last_d  <= w_grant_d;
            end

            case (r_state)
                S_IDLE: begin
                    r_beat <= '0;
                end
                S_RD: begin
                    if (r_beat != '0) begin
                        r_line[w_cap_lo * DATA_WIDTH +: DATA_WIDTH] <= r_ram_q;
                    end
                    if (r_beat == LAST_RD) begin
                        if (r_grant_d) begin
                            r_d_datain <= w_line_done;
                        end else begin
                            r_i_datain <= w_line_done;
                        end
                    end else begin
                        r_beat <= r_beat + BEAT_ONE;
                    end
                end
                S_WR: begin
                    r_beat <= r_beat + BEAT_ONE;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_line_mem_responder
//   Directed bench for line_mem_responder: reset state, write/read latency,
//   offset-bit masking, round-robin order, no starvation, address wrap and
//   reset in the middle of a line write.
// ----------------------------------------------------------------------------
module tb_line_mem_responder;

    logic clk = 1'b0;
    logic rst;
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    line_mem_responder_if #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) bus ();

    line_mem_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10-unit clock; cyc numbers the cycle that starts at each rising edge.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Line whose beat k holds first + k.
    function automatic logic [255:0] mkLine(input logic [31:0] first);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) begin
            l[k*32 +: 32] = first + 32'(k);
        end
        return l;
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Strobes the selected ports for exactly one cycle; n is that cycle.
    // Inputs are scrambled afterwards since the responder must latch them.
    task automatic applyStimulus(input bit doI, input logic [31:0] iAddr,
                                 input bit doD, input bit dRw,
                                 input logic [31:0] dAddr, input logic [255:0] dLine,
                                 output int n);
        @(posedge clk); #1;
        n = cyc;
        bus.ICACHE_strobe  = doI;
        bus.ICACHE_addr    = iAddr;
        bus.DCACHE_strobe  = doD;
        bus.DCACHE_rw      = dRw;
        bus.DCACHE_addr    = dAddr;
        bus.DCACHE_dataout = dLine;
        @(posedge clk); #1;
        bus.ICACHE_strobe  = 1'b0;
        bus.DCACHE_strobe  = 1'b0;
        bus.ICACHE_addr    = 32'hDEAD_BEEF;
        bus.DCACHE_addr    = 32'hDEAD_BEEF;
        bus.DCACHE_rw      = ~dRw;
        bus.DCACHE_dataout = ~dLine;
    endtask

    // Waits (bounded) for done on one port; doneCyc = -1 if it never came.
    task automatic waitDone(input bit isD, input int limit, output int doneCyc);
        doneCyc = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if ((isD ? bus.DCACHE_done : bus.ICACHE_done) === 1'b1) begin
                doneCyc = cyc;
                break;
            end
        end
        if (doneCyc != -1) begin
            checkOutput(isD ? "I_done_low_with_D" : "D_done_low_with_I",
                        256'(isD ? bus.ICACHE_done : bus.DCACHE_done), 256'(0));
        end
    endtask

    initial begin
        int           n;
        int           n2;
        int           d1;
        int           d2;
        logic [255:0] expLine;
        logic [255:0] newLine;
        logic [31:0]  word;

        rst                = 1'b1;
        bus.ICACHE_strobe  = 1'b0;
        bus.ICACHE_addr    = '0;
        bus.DCACHE_strobe  = 1'b0;
        bus.DCACHE_addr    = '0;
        bus.DCACHE_rw      = 1'b0;
        bus.DCACHE_dataout = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_I_done",   256'(bus.ICACHE_done), 256'(0));
        checkOutput("rst_D_done",   256'(bus.DCACHE_done), 256'(0));
        checkOutput("rst_I_datain", bus.ICACHE_datain, 256'(0));
        checkOutput("rst_D_datain", bus.DCACHE_datain, 256'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Preload words 16..23 = 0x100..0x107 with a D write; done at N+10.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0040, mkLine(32'h100), n);
        waitDone(1'b1, 40, d1);
        checkOutput("wr16_done_cycle", 256'(d1), 256'(n + 10));

        // I read of that line; done at N+11 for one cycle only.
        applyStimulus(1'b1, 32'h8000_0040, 1'b0, 1'b0, 32'h0, 256'(0), n);
        waitDone(1'b0, 40, d1);
        checkOutput("rd16_done_cycle", 256'(d1), 256'(n + 11));
        checkOutput("rd16_line", bus.ICACHE_datain, mkLine(32'h100));
        word = bus.ICACHE_datain[31:0];
        checkOutput("rd16_beat0", 256'(word), 256'(32'h100));
        word = bus.ICACHE_datain[255:224];
        checkOutput("rd16_beat7", 256'(word), 256'(32'h107));
        checkOutput("rd16_D_datain_untouched", bus.DCACHE_datain, 256'(0));
        @(negedge clk);
        checkOutput("rd16_done_one_cycle", 256'(bus.ICACHE_done), 256'(0));

        // D write 0x8000_0020, then D read 0x8000_0024 (offset ignored).
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0020, mkLine(32'hA0), n);
        waitDone(1'b1, 40, d1);
        checkOutput("wrA0_done_cycle", 256'(d1), 256'(n + 10));
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h8000_0024, 256'(0), n);
        waitDone(1'b1, 40, d1);
        checkOutput("rdA0_done_cycle", 256'(d1), 256'(n + 11));
        checkOutput("rdA0_line", bus.DCACHE_datain, mkLine(32'hA0));

        // Reset clears datain and restores last_grant = I.
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst2_I_datain", bus.ICACHE_datain, 256'(0));
        checkOutput("rst2_D_datain", bus.DCACHE_datain, 256'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Simultaneous strobes after reset: D first, I BEATS+3 cycles later.
        applyStimulus(1'b1, 32'h8000_0040, 1'b1, 1'b0, 32'h8000_0020, 256'(0), n);
        waitDone(1'b1, 40, d1);
        checkOutput("rr1_D_done_cycle", 256'(d1), 256'(n + 11));
        checkOutput("rr1_D_line", bus.DCACHE_datain, mkLine(32'hA0));
        waitDone(1'b0, 40, d2);
        checkOutput("rr1_I_done_cycle", 256'(d2), 256'(d1 + 11));
        checkOutput("rr1_I_line", bus.ICACHE_datain, mkLine(32'h100));

        // D alone (last_grant = D), then simultaneous again: I goes first.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h8000_0020, 256'(0), n);
        waitDone(1'b1, 40, d1);
        checkOutput("solo_D_done_cycle", 256'(d1), 256'(n + 11));
        applyStimulus(1'b1, 32'h8000_0020, 1'b1, 1'b0, 32'h8000_0040, 256'(0), n);
        waitDone(1'b0, 40, d1);
        checkOutput("rr2_I_done_cycle", 256'(d1), 256'(n + 11));
        checkOutput("rr2_I_line", bus.ICACHE_datain, mkLine(32'hA0));
        waitDone(1'b1, 40, d2);
        checkOutput("rr2_D_done_cycle", 256'(d2), 256'(d1 + 11));
        checkOutput("rr2_D_line", bus.DCACHE_datain, mkLine(32'h100));

        // D re-strobes right after its done while I waits: I must go next.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h8000_0020, 256'(0), n);
        applyStimulus(1'b1, 32'h8000_0040, 1'b0, 1'b0, 32'h0, 256'(0), d2);
        waitDone(1'b1, 40, d1);
        checkOutput("stv_D1_done_cycle", 256'(d1), 256'(n + 11));
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h8000_0040, 256'(0), n2);
        checkOutput("stv_D2_strobe_cycle", 256'(n2), 256'(n + 12));
        waitDone(1'b0, 40, d1);
        checkOutput("stv_I_done_cycle", 256'(d1), 256'(n + 22));
        checkOutput("stv_I_line", bus.ICACHE_datain, mkLine(32'h100));
        waitDone(1'b1, 40, d1);
        checkOutput("stv_D2_done_cycle", 256'(d1), 256'(n + 33));
        checkOutput("stv_D2_line", bus.DCACHE_datain, mkLine(32'h100));

        // Address one RAM size past the base wraps to word 0.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0000, mkLine(32'hC0), n);
        waitDone(1'b1, 40, d1);
        checkOutput("wrC0_done_cycle", 256'(d1), 256'(n + 10));
        applyStimulus(1'b1, 32'h8000_4000, 1'b0, 1'b0, 32'h0, 256'(0), n);
        waitDone(1'b0, 40, d1);
        checkOutput("wrap_done_cycle", 256'(d1), 256'(n + 11));
        checkOutput("wrap_line", bus.ICACHE_datain, mkLine(32'hC0));

        // Reset during write beat 3: no done, beats 0..2 land, rest old.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0060, mkLine(32'hD0), n);
        waitDone(1'b1, 40, d1);
        checkOutput("wrD0_done_cycle", 256'(d1), 256'(n + 10));
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0060, mkLine(32'hE0), n);
        repeat (4) begin
            @(posedge clk); #1;
        end
        checkOutput("abort_cycle", 256'(cyc), 256'(n + 5));
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_D_done", 256'(bus.DCACHE_done), 256'(0));
        checkOutput("abort_D_datain", bus.DCACHE_datain, 256'(0));
        checkOutput("abort_I_datain", bus.ICACHE_datain, 256'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        waitDone(1'b1, 15, d1);
        checkOutput("abort_no_done", 256'(d1), 256'(-1));

        expLine = mkLine(32'hD0);
        newLine = mkLine(32'hE0);
        expLine[95:0] = newLine[95:0];
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h8000_0060, 256'(0), n);
        waitDone(1'b1, 40, d1);
        checkOutput("post_abort_done_cycle", 256'(d1), 256'(n + 11));
        checkOutput("post_abort_line", bus.DCACHE_datain, expLine);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
